// File: rtl/iter_mul.sv
// -----------------------------------------------------------------------------
// iter_mul -- iterative shift-add multiplier, one multiplier bit per clock.
//
// Both operands are widened by one bit (sign- or zero-extended according to
// mul_signed), so a single datapath handles signed and unsigned products.
// The widened multiplier's top bit carries weight -2^WIDTH. That is why the
// final iteration (count == WIDTH) subtracts its partial product instead of
// adding it.
//
// Build option:
//   ITER_MUL_EARLY_TERM_EN  When defined, BUSY finishes on the first edge
//                           where the remaining multiplier bits are all zero.
//                           Latency is then 1..WIDTH+1 edges. Without it,
//                           latency is always WIDTH+1 edges. The product is
//                           identical in both builds.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous active-high reset
//   in_valid    operand pair offered
//   in_ready    block is idle and can accept an operand pair
//   src1        multiplier operand   [WIDTH-1:0]
//   src2        multiplicand operand [WIDTH-1:0]
//   mul_signed  1 = two's complement operands, 0 = unsigned
//   flush       synchronous abort of the current operation
//   out_valid   result available
//   out_ready   consumer takes the result
//   result      product [2*WIDTH-1:0]
// -----------------------------------------------------------------------------
module iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     src1,
  input  logic [WIDTH-1:0]     src2,
  input  logic                 mul_signed,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int ACCW = 2*WIDTH + 2;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [CW-1:0]   r_count;
  logic [ACCW-1:0] r_acc;
  logic [ACCW-1:0] r_mcand;
  logic [WIDTH:0]  r_mplier;

  logic [ACCW-1:0] w_addend;
  logic [ACCW-1:0] w_sum;
  logic            w_last;
  logic [1:0]      w_unused_acc_msbs;

  assign w_last   = (r_count == LAST);
  assign w_addend = r_mcand & {ACCW{r_mplier[0]}};
  // Last iteration handles the negative-weight sign bit of the multiplier.
  assign w_sum    = w_last ? (r_acc + ~w_addend + ACCW'(1)) : (r_acc + w_addend);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            r_state     <= S_BUSY;
            r_in_ready  <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
            r_mplier    <= {mul_signed & src1[WIDTH-1], src1};
            r_mcand     <= {{(WIDTH+2){mul_signed & src2[WIDTH-1]}}, src2};
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end
`ifdef ITER_MUL_EARLY_TERM_EN
          // No set bits left: every remaining partial product is zero.
          else if (r_mplier == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
`endif
          else begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (w_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Flush and consume both return to IDLE; neither keeps the result.
          if (flush || out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The two guard bits only absorb carries; the product is the low 2*WIDTH.
  assign w_unused_acc_msbs = r_acc[ACCW-1:2*WIDTH];

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_acc[2*WIDTH-1:0];

endmodule

// File: doc/iter_mul.md
ITER_MUL -- requirements
Module: iter_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port src1  input  WIDTH  multiplier operand.
REQ-007 SHALL have port src2  input  WIDTH  multiplicand operand.
REQ-008 SHALL have port mul_signed  input  1  1 = both operands two's complement, 0 = both unsigned; sampled with operands.
REQ-009 SHALL have port flush  input  1  synchronous abort of the current operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  2*WIDTH  product.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-014 SHALL accept when in_valid && in_ready && !flush: IDLE->BUSY, count=0, accumulator=0, operands extended to WIDTH+1 bits (sign-extend if mul_signed, else zero-extend).
REQ-015 SHALL each BUSY edge add (multiplicand AND replicated multiplier[0]) into a 2*WIDTH+2-bit accumulator, shift multiplicand left 1, shift multiplier right 1 with zero fill, increment count.
REQ-016 SHALL on the iteration with count==WIDTH subtract (invert operand, carry-in 1) instead of add, and move BUSY->DONE on that edge.
REQ-017 SHALL assert out_valid exactly WIDTH+1 rising edges after the accepting edge (compiled without REQ-027 macro).
REQ-018 SHALL drive result = accumulator[2*WIDTH-1:0], stable while out_valid=1.
REQ-019 SHALL hold DONE, out_valid and result while out_ready=0; DONE->IDLE on the edge where out_ready=1.
REQ-020 SHALL ignore in_valid, src1, src2, mul_signed outside IDLE.
REQ-021 SHALL on flush=1 in BUSY or DONE go to IDLE next edge, discard result, never assert out_valid for that operation.
REQ-022 SHALL give flush priority over acceptance in IDLE and over out_ready in DONE.
REQ-023 SHALL accept a new operation no earlier than the edge after DONE->IDLE (one idle cycle minimum between results).

Reset
REQ-024 SHALL on reset=1, immediately and independent of clk: state=IDLE, count=0, accumulator=0, multiplier/multiplicand registers=0.
REQ-025 SHALL after reset present in_ready=1, out_valid=0, result=0.
REQ-026 SHALL abandon any in-flight operation on reset with no later out_valid for it.

Configuration
REQ-027 SHALL, when ITER_MUL_EARLY_TERM_EN is defined, move BUSY->DONE on any BUSY edge where the multiplier register is all zero, leaving the accumulator unchanged on that edge; latency then 1..WIDTH+1 edges.
REQ-028 SHALL, when ITER_MUL_EARLY_TERM_EN is undefined, have fixed latency WIDTH+1 edges regardless of operand values; results identical in both builds.

Verification (WIDTH=32)
REQ-029 SHALL check unsigned 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE00000001, out_valid exactly 33 edges after accept, in_ready=0 throughout.
REQ-030 SHALL check signed 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFFFFFFFFFE; signed 0x80000000*0x80000000 -> 0x4000000000000000.
REQ-031 SHALL check out_ready held 0 for 5 cycles after out_valid -> out_valid and result unchanged, in_ready=0; out_ready=1 -> next cycle in_ready=1, out_valid=0.
REQ-032 SHALL check flush at count=10 -> IDLE next edge, no out_valid; following unsigned 7*6 -> 42 after 33 edges.
REQ-033 SHALL check reset asserted mid-BUSY between clock edges -> in_ready=1, out_valid=0, result=0 before next edge; new operation correct afterwards.
REQ-034 SHALL check with ITER_MUL_EARLY_TERM_EN unsigned 5*3 -> result 15, out_valid 4 edges after accept; src1=0 -> result 0 after 1 edge.
